// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps note-on/off events onto a fixed voice pool
// using a one-voice-per-clock scan, with a one-entry pending buffer and
// oldest-voice stealing.
module voice_alloc #(
   parameter int unsigned VOICES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  note_on,
   input  logic                  note_off,
   input  logic                  all_off,
   input  logic [6:0]            note,
   input  logic [6:0]            velocity,
   output logic [VOICES-1:0]     voice_gate,
   output logic [7*VOICES-1:0]   voice_note,
   output logic [7*VOICES-1:0]   voice_vel,
   output logic [VOICES-1:0]     voice_trig,
   output logic                  steal,
   output logic                  busy,
   output logic                  overflow
);

   localparam int unsigned AW = (VOICES > 1) ? $clog2(VOICES) : 1;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SCAN  = 2'd1;
   localparam logic [1:0] APPLY = 2'd2;

   typedef logic [AW-1:0] idx_t;

   logic [1:0]        state_q, state_d;
   idx_t              idx_q, idx_d;
   logic              cur_on_q, cur_on_d;
   logic [6:0]        cur_note_q, cur_note_d;
   logic [6:0]        cur_vel_q, cur_vel_d;
   logic              pend_valid_q, pend_valid_d;
   logic              pend_on_q, pend_on_d;
   logic [6:0]        pend_note_q, pend_note_d;
   logic [6:0]        pend_vel_q, pend_vel_d;
   logic              m_found_q, m_found_d;
   idx_t              m_idx_q, m_idx_d;
   logic              f_found_q, f_found_d;
   idx_t              f_idx_q, f_idx_d;
   idx_t              f_age_q, f_age_d;
   idx_t              o_idx_q, o_idx_d;
   idx_t              o_age_q, o_age_d;
   logic [VOICES-1:0] gate_q, gate_d;
   logic [6:0]        note_q [VOICES];
   logic [6:0]        note_d [VOICES];
   logic [6:0]        vel_q [VOICES];
   logic [6:0]        vel_d [VOICES];
   idx_t              age_q [VOICES];
   idx_t              age_d [VOICES];
   logic [VOICES-1:0] trig_q, trig_d;
   logic              steal_q, steal_d;
   logic              ovf_q, ovf_d;

   logic              ev, ev_on, start, do_touch;
   idx_t              tgt, old_age;

   // A velocity-0 note-on, or on+off together, counts as OFF.
   assign ev    = note_on | note_off;
   assign ev_on = note_on & ~note_off & (velocity != 7'd0);

   // Next-state logic: event capture, pending buffer, scan trackers and apply.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cur_on_d     = cur_on_q;
      cur_note_d   = cur_note_q;
      cur_vel_d    = cur_vel_q;
      pend_valid_d = pend_valid_q;
      pend_on_d    = pend_on_q;
      pend_note_d  = pend_note_q;
      pend_vel_d   = pend_vel_q;
      m_found_d    = m_found_q;
      m_idx_d      = m_idx_q;
      f_found_d    = f_found_q;
      f_idx_d      = f_idx_q;
      f_age_d      = f_age_q;
      o_idx_d      = o_idx_q;
      o_age_d      = o_age_q;
      gate_d       = gate_q;
      note_d       = note_q;
      vel_d        = vel_q;
      age_d        = age_q;
      trig_d       = '0;
      steal_d      = 1'b0;
      ovf_d        = ovf_q;
      start        = 1'b0;
      do_touch     = 1'b0;
      tgt          = '0;
      old_age      = '0;

      if (all_off) begin
         // Release everything; the coincident event and any pending one are lost.
         gate_d       = '0;
         state_d      = IDLE;
         pend_valid_d = 1'b0;
      end else begin
         // Events arriving mid-processing go to the single pending slot.
         if (ev && state_q != IDLE) begin
            if (pend_valid_q) begin
               ovf_d = 1'b1;
            end else begin
               pend_valid_d = 1'b1;
               pend_on_d    = ev_on;
               pend_note_d  = note;
               pend_vel_d   = velocity;
            end
         end

         case (state_q)
            IDLE: begin
               if (pend_valid_q) begin
                  start        = 1'b1;
                  cur_on_d     = pend_on_q;
                  cur_note_d   = pend_note_q;
                  cur_vel_d    = pend_vel_q;
                  pend_valid_d = ev;
                  if (ev) begin
                     pend_on_d   = ev_on;
                     pend_note_d = note;
                     pend_vel_d  = velocity;
                  end
               end else if (ev) begin
                  start      = 1'b1;
                  cur_on_d   = ev_on;
                  cur_note_d = note;
                  cur_vel_d  = velocity;
               end
            end
            SCAN: begin
               if (!m_found_q && gate_q[idx_q] && note_q[idx_q] == cur_note_q) begin
                  m_found_d = 1'b1;
                  m_idx_d   = idx_q;
               end
               if (!gate_q[idx_q] && (!f_found_q || age_q[idx_q] > f_age_q)) begin
                  f_found_d = 1'b1;
                  f_idx_d   = idx_q;
                  f_age_d   = age_q[idx_q];
               end
               if (idx_q == '0 || age_q[idx_q] > o_age_q) begin
                  o_idx_d = idx_q;
                  o_age_d = age_q[idx_q];
               end
               if (idx_q == idx_t'(VOICES - 1)) begin
                  state_d = APPLY;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            APPLY: begin
               tgt = m_found_q ? m_idx_q : (f_found_q ? f_idx_q : o_idx_q);
               if (cur_on_q) begin
                  gate_d[tgt] = 1'b1;
                  note_d[tgt] = cur_note_q;
                  vel_d[tgt]  = cur_vel_q;
                  trig_d[tgt] = 1'b1;
                  steal_d     = ~m_found_q & ~f_found_q;
                  do_touch    = 1'b1;
               end else if (m_found_q) begin
                  // Note and velocity stay so the release tail keeps its pitch.
                  gate_d[tgt] = 1'b0;
                  do_touch    = 1'b1;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase

         if (start) begin
            state_d   = SCAN;
            idx_d     = '0;
            m_found_d = 1'b0;
            f_found_d = 1'b0;
            f_age_d   = '0;
            o_idx_d   = '0;
            o_age_d   = '0;
         end

         // Touched voice becomes most recent; younger ranks shift up by one.
         if (do_touch) begin
            old_age = age_q[tgt];
            for (int j = 0; j < VOICES; j++) begin
               if (idx_t'(j) == tgt) begin
                  age_d[j] = '0;
               end else if (age_q[j] < old_age) begin
                  age_d[j] = age_q[j] + 1'b1;
               end
            end
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         cur_on_q     <= 1'b0;
         cur_note_q   <= '0;
         cur_vel_q    <= '0;
         pend_valid_q <= 1'b0;
         pend_on_q    <= 1'b0;
         pend_note_q  <= '0;
         pend_vel_q   <= '0;
         m_found_q    <= 1'b0;
         m_idx_q      <= '0;
         f_found_q    <= 1'b0;
         f_idx_q      <= '0;
         f_age_q      <= '0;
         o_idx_q      <= '0;
         o_age_q      <= '0;
         gate_q       <= '0;
         trig_q       <= '0;
         steal_q      <= 1'b0;
         ovf_q        <= 1'b0;
         for (int i = 0; i < VOICES; i++) begin
            note_q[i] <= '0;
            vel_q[i]  <= '0;
            age_q[i]  <= idx_t'(VOICES - 1 - i);
         end
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cur_on_q     <= cur_on_d;
         cur_note_q   <= cur_note_d;
         cur_vel_q    <= cur_vel_d;
         pend_valid_q <= pend_valid_d;
         pend_on_q    <= pend_on_d;
         pend_note_q  <= pend_note_d;
         pend_vel_q   <= pend_vel_d;
         m_found_q    <= m_found_d;
         m_idx_q      <= m_idx_d;
         f_found_q    <= f_found_d;
         f_idx_q      <= f_idx_d;
         f_age_q      <= f_age_d;
         o_idx_q      <= o_idx_d;
         o_age_q      <= o_age_d;
         gate_q       <= gate_d;
         note_q       <= note_d;
         vel_q        <= vel_d;
         age_q        <= age_d;
         trig_q       <= trig_d;
         steal_q      <= steal_d;
         ovf_q        <= ovf_d;
      end
   end

   // Output packing.
   always_comb begin
      for (int i = 0; i < VOICES; i++) begin
         voice_note[7*i +: 7] = note_q[i];
         voice_vel[7*i +: 7]  = vel_q[i];
      end
   end

   assign voice_gate = gate_q;
   assign voice_trig = trig_q;
   assign steal      = steal_q;
   assign overflow   = ovf_q;
   assign busy       = (state_q != IDLE) | pend_valid_q;

endmodule
